// File: rtl/tagged_splitter_if.sv
// Handshake bundle for tagged_splitter: one tagged input stream and NUM_CHANNELS payload streams.
// The slave modport is the splitter's view; the master modport is the producer/consumer side.
interface tagged_splitter_if #(
  parameter int NUM_CHANNELS      = 2,
  parameter int CHANNEL_WIDTH_IN  = 64,
  parameter int CHANNEL_WIDTH_OUT = 32
);
  logic [CHANNEL_WIDTH_IN-1:0]               in_data;
  logic                                      in_valid;
  logic                                      in_ready;
  logic [CHANNEL_WIDTH_OUT*NUM_CHANNELS-1:0] out_data;
  logic [NUM_CHANNELS-1:0]                   out_valid;
  logic [NUM_CHANNELS-1:0]                   out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/tagged_splitter.sv
// Routes tagged input words to per-channel FIFOs by the tag field; out-of-range tags are dropped and counted.
// Optional SPLITTER_STATS_EN adds stats_count, a per-channel count of popped words.
module tagged_splitter #(
  parameter int NUM_CHANNELS      = 2,
  parameter int CHANNEL_WIDTH_IN  = 64,
  parameter int CHANNEL_WIDTH_OUT = 32,
  parameter int TAG_MSB           = 55,
  parameter int TAG_LSB           = 48,
  parameter int FIFO_DEPTH        = 2
) (
  input  logic                clk,
  input  logic                reset,
  tagged_splitter_if.slave    bus,
  output logic [15:0]         drop_count
`ifdef SPLITTER_STATS_EN
  ,
  output logic [32*NUM_CHANNELS-1:0] stats_count
`endif
);
  localparam int TAG_W = TAG_MSB - TAG_LSB + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0]        tag;
  logic                    tag_ok;
  logic                    accept;
  logic [NUM_CHANNELS-1:0] sel;
  logic [NUM_CHANNELS-1:0] full;
  logic [NUM_CHANNELS-1:0] push;
  logic [NUM_CHANNELS-1:0] pop;

  assign tag    = bus.in_data[TAG_MSB:TAG_LSB];
  assign tag_ok = 32'(tag) < 32'(NUM_CHANNELS);

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sel[i] = tag_ok && (32'(tag) == 32'(i));
    end
  end

  // Readiness depends only on the target FIFO's fill state, never on out_ready.
  assign bus.in_ready = !reset && !(|(sel & full));
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = sel & {NUM_CHANNELS{accept}};

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [CHANNEL_WIDTH_OUT-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             count;

    assign full[i]          = (count == CNT_W'(FIFO_DEPTH));
    assign bus.out_valid[i] = (count != '0);
    assign pop[i]           = bus.out_valid[i] && bus.out_ready[i];
    assign bus.out_data[i*CHANNEL_WIDTH_OUT +: CHANNEL_WIDTH_OUT] = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        // NOTE: the storage is reset as well because the head entry drives out_data, which must read 0 after reset.
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem[j] <= '0;
        end
      end else begin
        if (push[i]) begin
          mem[wr_ptr] <= bus.in_data[CHANNEL_WIDTH_OUT-1:0];
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end

`ifdef SPLITTER_STATS_EN
    logic [31:0] pop_count;

    always_ff @(posedge clk) begin
      if (reset) begin
        pop_count <= '0;
      end else if (pop[i]) begin
        pop_count <= pop_count + 32'd1;
      end
    end

    assign stats_count[i*32 +: 32] = pop_count;
`endif
  end

  // Saturates so a long run of bad tags cannot wrap back to a small count.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (accept && !tag_ok && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_tagged_splitter.sv
// Scoreboard bench for tagged_splitter: a negedge monitor models per-channel queues, in_ready and
// drop_count, while scenario tasks drive stimulus and add their own inline checks.
module tb_tagged_splitter;
  localparam int NCH   = 2;
  localparam int WIN   = 64;
  localparam int WOUT  = 32;
  localparam int DEPTH = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] drop_count;
`ifdef SPLITTER_STATS_EN
  logic [32*NCH-1:0] stats_count;
`endif

  tagged_splitter_if #(.NUM_CHANNELS(NCH), .CHANNEL_WIDTH_IN(WIN), .CHANNEL_WIDTH_OUT(WOUT)) bus ();

  tagged_splitter #(
    .NUM_CHANNELS(NCH), .CHANNEL_WIDTH_IN(WIN), .CHANNEL_WIDTH_OUT(WOUT),
    .TAG_MSB(55), .TAG_LSB(48), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .drop_count (drop_count)
`ifdef SPLITTER_STATS_EN
    ,
    .stats_count(stats_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks  = 0;
  int          errors  = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int          exp_drop = 0;
  int unsigned exp_stats [NCH];
  bit          started = 1'b0;

  function automatic int qsize(input int ch);
    return (ch == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [31:0] qhead(input int ch);
    return (ch == 0) ? q0[0] : q1[0];
  endfunction

  function automatic logic [WIN-1:0] make_word(input logic [7:0] tag, input logic [31:0] pl);
    logic [15:0] junk;
    junk = 16'($urandom);
    return {8'hC3, tag, junk, pl};
  endfunction

  // Scoreboard monitor: compares against pre-edge model state, then applies this edge's handshakes.
  always @(negedge clk) begin
    int t;
    bit exp_rdy;
    t       = int'(bus.in_data[55:48]);
    exp_rdy = !reset && ((t >= NCH) || (qsize(t) < DEPTH));
    checks++;
    if (bus.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready at %0t: got %b expected %b (tag %0d)", $time, bus.in_ready, exp_rdy, t);
    end
    if (started) begin
      checks++;
      if (drop_count !== 16'(exp_drop)) begin
        errors++;
        $display("FAIL drop_count at %0t: got %0d expected %0d", $time, drop_count, exp_drop);
      end
`ifdef SPLITTER_STATS_EN
      for (int ch = 0; ch < NCH; ch++) begin
        checks++;
        if (stats_count[ch*32 +: 32] !== exp_stats[ch]) begin
          errors++;
          $display("FAIL stats_count[%0d] at %0t: got %0d expected %0d", ch, $time,
                   stats_count[ch*32 +: 32], exp_stats[ch]);
        end
      end
`endif
      for (int ch = 0; ch < NCH; ch++) begin
        checks++;
        if (bus.out_valid[ch] !== (qsize(ch) > 0)) begin
          errors++;
          $display("FAIL out_valid[%0d] at %0t: got %b expected %b", ch, $time, bus.out_valid[ch], qsize(ch) > 0);
        end
        if (!reset && (qsize(ch) > 0) && bus.out_ready[ch]) begin
          checks++;
          if (bus.out_data[ch*WOUT +: WOUT] !== qhead(ch)) begin
            errors++;
            $display("FAIL out_data[%0d] at %0t: got %h expected %h", ch, $time,
                     bus.out_data[ch*WOUT +: WOUT], qhead(ch));
          end
          if (ch == 0) void'(q0.pop_front());
          else         void'(q1.pop_front());
          exp_stats[ch]++;
        end
      end
    end
    if (reset) begin
      q0.delete();
      q1.delete();
      exp_drop = 0;
      for (int ch = 0; ch < NCH; ch++) exp_stats[ch] = 0;
      started = 1'b1;
    end else if (bus.in_valid && exp_rdy) begin
      if (t == 0)      q0.push_back(bus.in_data[31:0]);
      else if (t == 1) q1.push_back(bus.in_data[31:0]);
      else if (exp_drop < 65535) exp_drop++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word and holds it until the handshake completes, within a bounded wait.
  task automatic send(input logic [7:0] tag, input logic [31:0] pl);
    int n;
    bus.in_data  = make_word(tag, pl);
    bus.in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      n++;
      if (n == 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout tag %0d: in_ready got %b expected 1 within 50 cycles", tag, bus.in_ready);
        break;
      end
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 2'b11;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL drain: out_valid got %b expected 00", bus.out_valid);
    end
    tick();
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = make_word(8'd0, 32'h1234_5678);
    bus.out_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks += 3;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ready cycle %0d: got %b expected 0", i, bus.in_ready);
      end
      if (bus.out_valid !== 2'b00) begin
        errors++;
        $display("FAIL reset_out_valid cycle %0d: got %b expected 00", i, bus.out_valid);
      end
      if (drop_count !== 16'd0) begin
        errors++;
        $display("FAIL reset_drop_count cycle %0d: got %0d expected 0", i, drop_count);
      end
    end
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_routing();
    bus.out_ready = 2'b11;
    bus.in_data   = make_word(8'd0, 32'hA5A5_A5A5);
    bus.in_valid  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL routing_ready: got %b expected 1", bus.in_ready);
    end
    tick();
    bus.in_data = make_word(8'd1, 32'h5A5A_5A5A);
    @(negedge clk);
    checks += 2;
    if (bus.out_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL routing_valid0: got %b expected 1", bus.out_valid[0]);
    end
    if (bus.out_data[31:0] !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL routing_data0: got %h expected a5a5a5a5", bus.out_data[31:0]);
    end
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus.out_valid !== 2'b10) begin
      errors++;
      $display("FAIL routing_valid1: got %b expected 10", bus.out_valid);
    end
    if (bus.out_data[63:32] !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL routing_data1: got %h expected 5a5a5a5a", bus.out_data[63:32]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 2'b10;
    send(8'd0, 32'h0000_0001);
    send(8'd0, 32'h0000_0002);
    bus.in_data  = make_word(8'd0, 32'h0000_0003);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_stall cycle %0d: in_ready got %b expected 0", i, bus.in_ready);
      end
      tick();
    end
    bus.out_ready = 2'b11;
    send(8'd0, 32'h0000_0003);
    send(8'd1, 32'h0000_0004);
    drain();
  endtask

  task automatic test_full_pop();
    bus.out_ready = 2'b00;
    send(8'd0, 32'hCAFE_0001);
    send(8'd0, 32'hCAFE_0002);
    bus.in_data   = make_word(8'd0, 32'hCAFE_0003);
    bus.in_valid  = 1'b1;
    bus.out_ready = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_blocked: in_ready got %b expected 0", bus.in_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_next: in_ready got %b expected 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      int  n;
      bit  acc;
      bus.in_data  = make_word(8'($urandom_range(0, 2)), $urandom);
      bus.in_valid = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
        bus.out_ready = 2'($urandom_range(0, 3));
        @(negedge clk);
        acc = (bus.in_ready === 1'b1);
        tick();
        n++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL back_to_back_timeout word %0d: in_ready got 0 expected 1 within 50 cycles", k);
      end
    end
    bus.in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 2'b00;
    send(8'd0, 32'hDEAD_0000);
    send(8'd1, 32'hDEAD_0001);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_pre: out_valid got %b expected 11", bus.out_valid);
    end
    tick();
    reset         = 1'b1;
    bus.out_ready = 2'b11;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_valid: out_valid got %b expected 00", bus.out_valid);
    end
`ifdef SPLITTER_STATS_EN
    checks++;
    if (stats_count !== '0) begin
      errors++;
      $display("FAIL reset_mid_stats: stats_count got %h expected 0", stats_count);
    end
`endif
    repeat (3) tick();
  endtask

  task automatic test_bad_tag();
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    bus.out_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      bus.in_data  = make_word(8'h05, 32'hBAD0_0000 + 32'(i));
      bus.in_valid = 1'b1;
      @(negedge clk);
      checks += 2;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bad_tag_ready %0d: got %b expected 1", i, bus.in_ready);
      end
      if (bus.out_valid !== 2'b00) begin
        errors++;
        $display("FAIL bad_tag_valid %0d: got %b expected 00", i, bus.out_valid);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (drop_count !== 16'd3) begin
      errors++;
      $display("FAIL bad_tag_count: got %0d expected 3", drop_count);
    end
    tick();
    bus.in_data  = make_word(8'h05, 32'h0);
    bus.in_valid = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_saturate: got %h expected ffff", drop_count);
    end
    tick();
    @(negedge clk);
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_hold: got %h expected ffff", drop_count);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 2'b00;
    test_reset();
    test_routing();
    test_backpressure();
    test_full_pop();
    test_back_to_back();
    test_reset_mid();
    test_bad_tag();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
